// File: rtl/freq_meter.sv
// Frequency meter: counts synchronized rising edges of sig_in over back-to-back gate windows.
// Optional min/max tracking of window counts is enabled by defining FREQ_METER_MINMAX_EN.
`timescale 1ns/1ps

module freq_meter #(
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    input  logic [CNT_W-1:0] thr_lo,
    input  logic [CNT_W-1:0] thr_hi,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_valid,
    output logic             cnt_sat,
    output logic             freq_ok,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_min,
    output logic [CNT_W-1:0] cnt_max
);

    localparam int unsigned GW = $clog2(GATE_CYCLES);
    localparam int unsigned FW = $clog2(SYNC_STAGES + 1);
    localparam logic [GW-1:0] GateLast = GW'(GATE_CYCLES - 1);
    localparam logic [FW-1:0] FlushLast = FW'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [1:0] {StIdle, StFlush, StGate} state_e;

    state_e             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               sig_d_q;
    logic               rise;
    logic [FW-1:0]      flush_q, flush_d;
    logic [GW-1:0]      gate_q, gate_d;
    logic [CNT_W-1:0]   edge_q, edge_d;
    logic               sat_q, sat_d;
    logic [CNT_W-1:0]   win_cnt;
    logic               win_sat;
    logic               report;
    logic               win_ok;

    logic [CNT_W-1:0]   cnt_out_q;
    logic               cnt_valid_q, cnt_sat_q, freq_ok_q, busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            sig_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~sig_d_q;

    // Count including this cycle's edge; used both for accumulation and the end-of-window report.
    always_comb begin
        win_cnt = edge_q;
        win_sat = sat_q;
        if (rise) begin
            if (edge_q == CntMax) begin
                win_sat = 1'b1;
            end else begin
                win_cnt = edge_q + 1'b1;
            end
        end
    end

    assign win_ok = ~win_sat && (thr_lo <= win_cnt) && (win_cnt <= thr_hi);

    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        gate_d  = gate_q;
        edge_d  = edge_q;
        sat_d   = sat_q;
        report  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (!en) begin
                    state_d = StIdle;
                end else if (flush_q == FlushLast) begin
                    state_d = StGate;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
            StGate: begin
                if (gate_q == GateLast) begin
                    // Window closes; the next cycle is cycle 0 of the following window.
                    report = 1'b1;
                    gate_d = '0;
                    edge_d = '0;
                    sat_d  = 1'b0;
                    if (!en) begin
                        state_d = StIdle;
                    end
                end else if (!en) begin
                    state_d = StIdle;
                end else begin
                    gate_d = gate_q + 1'b1;
                    edge_d = win_cnt;
                    sat_d  = win_sat;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StIdle) begin
            flush_d = '0;
            gate_d  = '0;
            edge_d  = '0;
            sat_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            flush_q <= '0;
            gate_q  <= '0;
            edge_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            gate_q  <= gate_d;
            edge_q  <= edge_d;
            sat_q   <= sat_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_out_q   <= '0;
            cnt_valid_q <= 1'b0;
            cnt_sat_q   <= 1'b0;
            freq_ok_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_valid_q <= report;
            busy_q      <= (state_d != StIdle);
            if (report) begin
                cnt_out_q <= win_cnt;
                cnt_sat_q <= win_sat;
                freq_ok_q <= win_ok;
            end
        end
    end

    assign cnt_out   = cnt_out_q;
    assign cnt_valid = cnt_valid_q;
    assign cnt_sat   = cnt_sat_q;
    assign freq_ok   = freq_ok_q;
    assign busy      = busy_q;

`ifdef FREQ_METER_MINMAX_EN
    logic [CNT_W-1:0] min_q, max_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= '1;
            max_q <= '0;
        end else if ((state_q == StIdle) && en) begin
            min_q <= '1;
            max_q <= '0;
        end else if (report) begin
            if (win_cnt < min_q) begin
                min_q <= win_cnt;
            end
            if (win_cnt > max_q) begin
                max_q <= win_cnt;
            end
        end
    end

    assign cnt_min = min_q;
    assign cnt_max = max_q;
`else
    assign cnt_min = '1;
    assign cnt_max = '0;
`endif

endmodule

// File: doc/freq_meter.md
# freq_meter

Synthesizable frequency meter that measures an asynchronous test signal against the system clock. It counts rising edges of `sig_in` over back-to-back gate windows of exactly `GATE_CYCLES` clock cycles and reports one count per window with a valid strobe, a saturation flag and a window-check result. It sits on the receiving side of clock-generation logic and is used on-chip and in benches to confirm that a generated clock runs at its programmed frequency.

## Interface
- `GATE_CYCLES`, 1000: gate window length in `clk` cycles, ≥ 2. At 100 MHz `clk`, one count equals 100 kHz.
- `CNT_W`, 16: width of the edge counter, the result and the thresholds.
- `SYNC_STAGES`, 2: number of `sig_in` synchronizer flops, ≥ 2.

- `clk`, input, 1: system/reference clock, rising-edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `en`, input, 1: run enable, level-sensitive.
- `sig_in`, input, 1: signal under measurement, asynchronous to `clk`.
- `thr_lo`, input, CNT_W: lower acceptable count, inclusive.
- `thr_hi`, input, CNT_W: upper acceptable count, inclusive.
- `cnt_out`, output, CNT_W: edge count of the last completed window.
- `cnt_valid`, output, 1: one-cycle strobe; `cnt_out` was updated this cycle.
- `cnt_sat`, output, 1: the last window's count saturated.
- `freq_ok`, output, 1: the last window satisfied `thr_lo` ≤ count ≤ `thr_hi` and did not saturate.
- `busy`, output, 1: the block is not in IDLE.
- `cnt_min`, output, CNT_W: smallest count since the run started (see Configuration).
- `cnt_max`, output, CNT_W: largest count since the run started (see Configuration).

## Operation
- `sig_in` passes through `SYNC_STAGES` flops to give `sig_s`. A further flop gives `sig_d`. A rising edge is `rise = sig_s & ~sig_d`.
- FSM states are IDLE, FLUSH and GATE.
  - IDLE: counters are held at 0. `en`=1 moves to FLUSH.
  - FLUSH: lasts `SYNC_STAGES`+1 cycles. It loads the synchronizer and `sig_d` so that no edge is detected from stale data. `rise` is ignored. At the end it moves to GATE with `gate_cnt`=0 and `edge_cnt`=0.
  - GATE: each cycle `gate_cnt` increments, and `edge_cnt` increments on `rise`. `edge_cnt` saturates at 2^CNT_W−1 and sets an internal sat flag.
- End of window, when `gate_cnt`=GATE_CYCLES−1 (the window's last cycle):
  - A `rise` in this cycle is included in the count.
  - On the next edge: `cnt_out` loads the count, `cnt_sat` loads the sat flag, `freq_ok` is updated, and `cnt_valid` is 1 for one cycle.
  - `gate_cnt` and `edge_cnt` restart with no gap, so that cycle is cycle 0 of the next window. A `rise` in cycle 0 counts toward the new window.
- `en`=0 in any state other than IDLE aborts immediately to IDLE on the next edge.
  - The partial window is discarded and no `cnt_valid` is issued.
  - `cnt_out`, `cnt_sat` and `freq_ok` hold their last values.
- If `en` falls in a window's last cycle, that window still reports. The abort takes effect together with the report.
- `thr_lo`/`thr_hi` are sampled in the window's last cycle. If `thr_lo` > `thr_hi`, then `freq_ok`=0.
- Input constraint: the high and low phases of `sig_in` must each be ≥ 1.5 `clk` periods. Faster inputs are undercounted; this is not detected.

## Timing
- Reset values: `cnt_out`=0, `cnt_valid`=0, `cnt_sat`=0, `freq_ok`=0, `busy`=0, `cnt_min`=all-ones, `cnt_max`=0, FSM in IDLE. All are asynchronous on `rst_n` low.
- `busy` goes to 1 on the edge after `en` is sampled high.
- The first `cnt_valid` occurs `SYNC_STAGES`+1+GATE_CYCLES+1 cycles after `en` is sampled high. After that, `cnt_valid` occurs every GATE_CYCLES cycles exactly.
- An edge on `sig_in` appears as `rise` `SYNC_STAGES`+1 cycles later. Counting is exact to within ±1 per window because of asynchronous sampling.
- All outputs are registered. There are no combinational paths from input to output.
- `rst_n` low mid-window: everything returns to reset values. After release, the block restarts from IDLE and, if `en`=1, starts a new FLUSH.

## Configuration
- `FREQ_METER_MINMAX_EN` defined:
  - `cnt_min` and `cnt_max` are registers updated on every `cnt_valid` with min/max(count).
  - Both reset to their reset values on IDLE→FLUSH.
- Not defined: `cnt_min` is tied to all-ones and `cnt_max` to 0, with no registers. The ports exist in both builds.

## Test plan
- `clk` at 100 MHz, GATE_CYCLES=1000, `sig_in` at 10 MHz (100 ns period), thr_lo=99, thr_hi=101 → every `cnt_valid` shows `cnt_out`=100 (±1), `freq_ok`=1, `cnt_sat`=0, and strobes are spaced exactly 1000 cycles apart.
- Same setup with `sig_in` at 30 MHz (33.33 ns) → `cnt_out` in 299..301. With thr_hi=200 → `freq_ok`=0.
- CNT_W=6, `sig_in` at 10 MHz → `cnt_out`=63, `cnt_sat`=1, `freq_ok`=0.
- Drop `en` 500 cycles into the second window → no further `cnt_valid`, `cnt_out` keeps the first result, `busy`=0 on the next edge.
- Assert `rst_n`=0 mid-window, then release with `en`=1 → all outputs at reset values, then the first `cnt_valid` arrives after FLUSH+GATE latency. With `FREQ_METER_MINMAX_EN`, alternate 5 MHz and 10 MHz windows → `cnt_min`=50, `cnt_max`=100.
